// File: rtl/dev_wb_fifo.sv
// Wishbone request FIFO serviced by the HS32 core through a small register window.
// Optional read timeout enabled by defining DEV_WB_FIFO_TIMEOUT_EN.
module dev_wb_fifo #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wb_stb,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_adr,
    input  logic [DW-1:0] wb_dat_i,
    output logic          wb_ack,
    output logic [DW-1:0] wb_dat_o,
    input  logic          stb,
    input  logic          we,
    input  logic [2:0]    addr,
    input  logic [DW-1:0] dtw,
    output logic [DW-1:0] dtr,
    output logic          ack,
    output logic          intrq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          mem_we_q  [DEPTH];
    logic [AW-1:0] mem_adr_q [DEPTH];
    logic [DW-1:0] mem_dat_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wb_ack_q, wb_ack_d;
    logic [DW-1:0] wb_dat_o_q, wb_dat_o_d;
    logic          ien_q, ien_d;
    logic          rd_pend_q, rd_pend_d;
    logic          intrq_q, intrq_d;
    logic [DW-1:0] resp_q, resp_d;

    logic full, empty, head_we, head_is_read;
    logic capture, reg_wr, resp_rd, pop_wr, pop, to_fire, to_bit;
    logic [8:0] status;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign head_we      = !empty && mem_we_q[rd_ptr_q];
    assign head_is_read = !empty && !mem_we_q[rd_ptr_q];

    // Only one read can be in flight: rd_pend blocks further captures.
    assign capture = wb_stb && !wb_ack_q && !full && !rd_pend_q;
    assign reg_wr  = stb && we;
    assign resp_rd = reg_wr && (addr == 3'd2) && head_is_read;
    assign pop_wr  = reg_wr && (addr == 3'd3) && head_we;
    assign pop     = pop_wr || resp_rd || to_fire;

`ifdef DEV_WB_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_flag_q, to_flag_d;

    // The count saturates if writes still sit ahead of the read; the forced
    // completion then happens as soon as the read reaches the head.
    assign to_fire = rd_pend_q && head_is_read && !resp_rd &&
                     (to_cnt_q >= TW'(TIMEOUT - 1));
    assign to_bit  = to_flag_q;

    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        if (capture && !wb_we)
            to_cnt_d = '0;
        else if (rd_pend_q && (to_cnt_q < TW'(TIMEOUT - 1)))
            to_cnt_d = to_cnt_q + TW'(1);
        if (to_fire)
            to_flag_d = 1'b1;
        else if (reg_wr && (addr == 3'd4) && dtw[1])
            to_flag_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end
`else
    assign to_fire = 1'b0;
    assign to_bit  = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wb_ack_d   = 1'b0;
        wb_dat_o_d = wb_dat_o_q;
        ien_d      = ien_q;
        rd_pend_d  = rd_pend_q;
        resp_d     = resp_q;
        intrq_d    = ien_q && !empty;

        if (capture)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (capture && !pop)
            count_d = count_q + CW'(1);
        else if (!capture && pop)
            count_d = count_q - CW'(1);

        if (capture && !wb_we)
            rd_pend_d = 1'b1;
        else if (resp_rd || to_fire)
            rd_pend_d = 1'b0;

        wb_ack_d = (capture && wb_we) || resp_rd || to_fire;

        if (resp_rd)
            wb_dat_o_d = dtw;
        else if (to_fire)
            wb_dat_o_d = DW'(32'hDEADBEEF);

        if (reg_wr && (addr == 3'd2))
            resp_d = dtw;
        if (reg_wr && (addr == 3'd4))
            ien_d = dtw[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_ack_q   <= 1'b0;
            wb_dat_o_q <= '0;
            ien_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            intrq_q    <= 1'b0;
            resp_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_ack_q   <= wb_ack_d;
            wb_dat_o_q <= wb_dat_o_d;
            ien_q      <= ien_d;
            rd_pend_q  <= rd_pend_d;
            intrq_q    <= intrq_d;
            resp_q     <= resp_d;
        end
    end

    // Entry storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_we_q[wr_ptr_q]  <= wb_we;
            mem_adr_q[wr_ptr_q] <= wb_adr;
            mem_dat_q[wr_ptr_q] <= wb_dat_i;
        end
    end

    assign status = {to_bit, rd_pend_q, head_we, full, empty, 4'(count_q)};

    always_comb begin
        dtr = '0;
        case (addr)
            3'd0: if (!empty) dtr = DW'(mem_adr_q[rd_ptr_q]);
            3'd1: if (!empty) dtr = mem_dat_q[rd_ptr_q];
            3'd2: dtr = resp_q;
            3'd3: dtr = DW'(status);
            3'd4: dtr = DW'(ien_q);
            default: dtr = '0;
        endcase
    end

    assign wb_ack   = wb_ack_q;
    assign wb_dat_o = wb_dat_o_q;
    assign intrq    = intrq_q;
    assign ack      = 1'b1;

endmodule

// File: tb/tb_dev_wb_fifo.sv
// Directed bench for dev_wb_fifo; the read-timeout case runs when DEV_WB_FIFO_TIMEOUT_EN is defined.
module tb_dev_wb_fifo;

`ifdef DEV_WB_FIFO_TIMEOUT_EN
    localparam int TO_P = 16;
`else
    localparam int TO_P = 1024;
`endif

    logic        clk;
    logic        reset_n;
    logic        wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_i;
    logic        wb_ack;
    logic [31:0] wb_dat_o;
    logic        stb, we;
    logic [2:0]  addr;
    logic [31:0] dtw;
    logic [31:0] dtr;
    logic        ack;
    logic        intrq;

    int vectors = 0;
    int errs    = 0;

    dev_wb_fifo #(.DEPTH(4), .AW(32), .DW(32), .TIMEOUT(TO_P)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .wb_dat_o(wb_dat_o),
        .stb(stb), .we(we), .addr(addr), .dtw(dtw), .dtr(dtr),
        .ack(ack), .intrq(intrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dtr;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        stb  = 1'b1;
        we   = 1'b1;
        addr = a;
        dtw  = d;
        tick();
        stb  = 1'b0;
        we   = 1'b0;
    endtask

    task automatic wb_post(input logic [31:0] a, input logic [31:0] d);
        wb_stb   = 1'b1;
        wb_we    = 1'b1;
        wb_adr   = a;
        wb_dat_i = d;
        tick();
        chk("post_ack", {31'd0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic        any_ack;
        reset_n = 1'b0;
        wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat_i = 0;
        stb = 0; we = 0; addr = 0; dtw = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_intrq", {31'd0, intrq}, 32'd0);
        reg_rd(3'd3, rd); chk("rst_status", rd, 32'h10);
        chk("mem_ack_tied", {31'd0, ack}, 32'd1);

        // Reset while a read is pending
        wb_stb = 1; wb_we = 0; wb_adr = 32'h3000_0010;
        tick();
        reg_rd(3'd3, rd); chk("read_pending_status", rd, 32'h81);
        tick();
        chk("read_no_ack", {31'd0, wb_ack}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, wb_ack}, 32'd0);
        chk("midrst_intrq", {31'd0, intrq}, 32'd0);
        reg_rd(3'd3, rd); chk("midrst_status", rd, 32'h10);
        wb_stb = 0;
        tick();
        reset_n = 1'b1;
        any_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_ack |= wb_ack;
        end
        chk("no_ack_after_reset", {31'd0, any_ack}, 32'd0);

        // Single posted write with interrupts enabled
        reg_wr(3'd4, 32'd1);
        reg_rd(3'd4, rd); chk("ien_readback", rd, 32'd1);
        wb_stb = 1; wb_we = 1; wb_adr = 32'h3000_0004; wb_dat_i = 32'h1234;
        tick();
        chk("w1_ack", {31'd0, wb_ack}, 32'd1);
        chk("w1_intrq_lag", {31'd0, intrq}, 32'd0);
        wb_stb = 0; wb_we = 0;
        tick();
        chk("w1_ack_pulse", {31'd0, wb_ack}, 32'd0);
        chk("w1_intrq", {31'd0, intrq}, 32'd1);
        reg_rd(3'd0, rd); chk("w1_head_adr", rd, 32'h3000_0004);
        reg_rd(3'd1, rd); chk("w1_head_dat", rd, 32'h1234);
        reg_rd(3'd3, rd); chk("w1_status", rd, 32'h41);
        reg_wr(3'd3, 32'd0);
        reg_rd(3'd3, rd); chk("w1_pop_status", rd, 32'h10);
        tick();
        chk("w1_intrq_clr", {31'd0, intrq}, 32'd0);

        // Fill to DEPTH, fifth request stalls until a POP
        for (int i = 0; i < 4; i++) wb_post(32'h100 + 32'(i * 4), 32'hA0 + 32'(i));
        reg_rd(3'd3, rd); chk("full_status", rd, 32'h64);
        wb_stb = 1; wb_we = 1; wb_adr = 32'h110; wb_dat_i = 32'hA4;
        any_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_ack |= wb_ack;
        end
        chk("full_stall_no_ack", {31'd0, any_ack}, 32'd0);
        reg_wr(3'd3, 32'd0);
        chk("full_pop_no_ack_yet", {31'd0, wb_ack}, 32'd0);
        tick();
        chk("fifth_ack", {31'd0, wb_ack}, 32'd1);
        wb_stb = 0; wb_we = 0;
        reg_rd(3'd3, rd); chk("fifth_status", rd, 32'h64);
        reg_rd(3'd0, rd); chk("fifth_head", rd, 32'h104);
        for (int i = 0; i < 3; i++) reg_wr(3'd3, 32'd0);
        reg_rd(3'd0, rd); chk("wrap_head", rd, 32'h110);
        reg_rd(3'd1, rd); chk("wrap_dat", rd, 32'hA4);
        reg_wr(3'd3, 32'd0);
        reg_rd(3'd3, rd); chk("drain_status", rd, 32'h10);

        // Read queued behind two writes
        wb_post(32'h200, 32'h11);
        wb_post(32'h204, 32'h22);
        wb_stb = 1; wb_we = 0; wb_adr = 32'h208;
        tick();
        reg_rd(3'd3, rd); chk("rd_queued_status", rd, 32'hC3);
        tick();
        chk("rd_wait0", {31'd0, wb_ack}, 32'd0);
        reg_wr(3'd3, 32'd0);
        chk("rd_wait1", {31'd0, wb_ack}, 32'd0);
        reg_wr(3'd3, 32'd0);
        chk("rd_wait2", {31'd0, wb_ack}, 32'd0);
        reg_rd(3'd3, rd); chk("rd_head_status", rd, 32'h81);
        reg_rd(3'd0, rd); chk("rd_head_adr", rd, 32'h208);
        reg_wr(3'd3, 32'd0);
        reg_rd(3'd3, rd); chk("pop_on_read_ignored", rd, 32'h81);
        reg_wr(3'd2, 32'hCAFE_F00D);
        chk("rd_ack", {31'd0, wb_ack}, 32'd1);
        chk("rd_data", wb_dat_o, 32'hCAFE_F00D);
        wb_stb = 0;
        tick();
        chk("rd_ack_pulse", {31'd0, wb_ack}, 32'd0);
        reg_rd(3'd3, rd); chk("rd_done_status", rd, 32'h10);
        reg_rd(3'd2, rd); chk("resp_readback", rd, 32'hCAFE_F00D);

        // Capture and POP in the same cycle
        wb_post(32'h300, 32'h33);
        wb_post(32'h304, 32'h34);
        wb_stb = 1; wb_we = 1; wb_adr = 32'h308; wb_dat_i = 32'h35;
        stb = 1; we = 1; addr = 3'd3; dtw = 0;
        tick();
        stb = 0; we = 0; wb_stb = 0; wb_we = 0;
        chk("simul_ack", {31'd0, wb_ack}, 32'd1);
        reg_rd(3'd3, rd); chk("simul_status", rd, 32'h42);
        reg_rd(3'd0, rd); chk("simul_head", rd, 32'h304);
        tick();
        reg_wr(3'd2, 32'h55);
        chk("resp_on_write_no_ack", {31'd0, wb_ack}, 32'd0);
        reg_rd(3'd3, rd); chk("resp_on_write_status", rd, 32'h42);
        reg_rd(3'd2, rd); chk("resp_on_write_stored", rd, 32'h55);
        reg_wr(3'd3, 32'd0);
        reg_rd(3'd0, rd); chk("simul_next_head", rd, 32'h308);
        reg_wr(3'd3, 32'd0);
        reg_wr(3'd3, 32'd0);
        reg_rd(3'd3, rd); chk("pop_empty_status", rd, 32'h10);
        reg_rd(3'd0, rd); chk("empty_adr", rd, 32'h0);
        reg_rd(3'd1, rd); chk("empty_dat", rd, 32'h0);
        reg_rd(3'd5, rd); chk("unmapped_reg", rd, 32'h0);

`ifdef DEV_WB_FIFO_TIMEOUT_EN
        begin
            int n_ack;
            n_ack = -1;
            wb_stb = 1; wb_we = 0; wb_adr = 32'h400;
            tick();
            for (int i = 1; i <= 40 && n_ack < 0; i++) begin
                tick();
                if (wb_ack) n_ack = i;
            end
            chk("to_ack_cycle", 32'(n_ack), 32'd16);
            chk("to_data", wb_dat_o, 32'hDEAD_BEEF);
            wb_stb = 0;
            tick();
            reg_rd(3'd3, rd); chk("to_status", rd, 32'h110);
            reg_wr(3'd4, 32'd3);
            reg_rd(3'd3, rd); chk("to_cleared", rd, 32'h10);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
